// File: rtl/trackball_position_counter_pkg.sv
// Shared types for the trackball position counter.
// Quadrature states, step codes and shifter modes.
package trackball_position_counter_pkg;

  // Quadrature level as {phase A, phase B}
  typedef enum logic [1:0] {
    Q00 = 2'b00,
    Q01 = 2'b01,
    Q11 = 2'b11,
    Q10 = 2'b10
  } quad_t;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_UP,
    STEP_DN,
    STEP_BAD
  } step_t;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SR   = 2'b01;
  localparam logic [1:0] MODE_SL   = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // 00->01->11->10->00 is forward; a two-bit jump is illegal
  function automatic step_t quad_step(quad_t prev, quad_t cur);
    step_t s;
    s = STEP_NONE;
    if (prev == cur) begin
      s = STEP_NONE;
    end else if ((prev ^ cur) == 2'b11) begin
      s = STEP_BAD;
    end else begin
      case ({prev, cur})
        {Q00, Q01},
        {Q01, Q11},
        {Q11, Q10},
        {Q10, Q00}: s = STEP_UP;
        default:    s = STEP_DN;
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/trackball_position_counter_axis.sv
// One trackball axis: synchroniser, level filter,
// Gray decoder and wrapping up/down counter with clear.
module quad_axis_decoder
  import trackball_position_counter_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_N      = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic             qa,
  input  logic             qb,
  input  logic             cl_n,
  output logic [CNT_W-1:0] count,
  output logic             err
);

  localparam int RUN_W = $clog2(FILT_N + 1);

  logic [SYNC_STAGES-1:0][1:0] sync;
  quad_t            sample;
  quad_t            cand;
  quad_t            filt;
  quad_t            prev;
  logic [RUN_W-1:0] run;
  logic             primed;
  step_t            step;
  logic [CNT_W-1:0] base;
  logic [CNT_W-1:0] count_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], {qa, qb}};
    end
  end

  assign sample = quad_t'(sync[SYNC_STAGES-1]);

  // Accept a new level only after FILT_N agreeing CE samples
  always_ff @(posedge clk) begin
    if (reset) begin
      cand <= Q00;
      filt <= Q00;
      run  <= '0;
    end else if (ce) begin
      if (sample != cand) begin
        cand <= sample;
        run  <= RUN_W'(1);
        if (FILT_N == 1) filt <= sample;
      end else if (run != RUN_W'(FILT_N)) begin
        run <= run + RUN_W'(1);
        if (run == RUN_W'(FILT_N - 1)) filt <= sample;
      end
    end
  end

  assign step = primed ? quad_step(prev, filt) : STEP_NONE;

  // Clear forces the base to zero but keeps this cycle's step
  always_comb begin
    base       = cl_n ? count : '0;
    count_next = base;
    unique case (step)
      STEP_UP: count_next = base + CNT_W'(1);
      STEP_DN: count_next = base - CNT_W'(1);
      default: count_next = base;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev   <= Q00;
      primed <= 1'b0;
      count  <= '0;
      err    <= 1'b0;
    end else if (ce) begin
      prev   <= filt;
      primed <= 1'b1;
      count  <= count_next;
      if (step == STEP_BAD) err <= 1'b1;
    end
  end

endmodule

// File: rtl/trackball_position_counter.sv
// Trackball position counter: two quadrature axes,
// LD hold registers and a CK1-stepped 16-bit shifter.
module trackball_position_counter
  import trackball_position_counter_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_N      = 3
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CE,
  input  logic       QA_X,
  input  logic       QB_X,
  input  logic       QA_Y,
  input  logic       QB_Y,
  input  logic       LD1n,
  input  logic       LD2n,
  input  logic       CL1n,
  input  logic       CL2n,
  input  logic       SHFT0,
  input  logic       SHFT1,
  input  logic       CK1,
  output logic [7:0] DOUT,
  output logic       SDATA,
  output logic       ERR
);

  logic [CNT_W-1:0]   count_x;
  logic [CNT_W-1:0]   count_y;
  logic [CNT_W-1:0]   hold_x;
  logic [CNT_W-1:0]   hold_y;
  logic               err_x;
  logic               err_y;
  logic               ld1_q;
  logic               ld2_q;
  logic               ck1_q;
  logic               ld1_fall;
  logic               ld2_fall;
  logic               ck1_rise;
  logic [1:0]         mode;
  logic [2*CNT_W-1:0] shifter;

  quad_axis_decoder #(
    .CNT_W      (CNT_W),
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_N     (FILT_N)
  ) u_axis_x (
    .clk  (CLK),
    .reset(RESET),
    .ce   (CE),
    .qa   (QA_X),
    .qb   (QB_X),
    .cl_n (CL1n),
    .count(count_x),
    .err  (err_x)
  );

  quad_axis_decoder #(
    .CNT_W      (CNT_W),
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_N     (FILT_N)
  ) u_axis_y (
    .clk  (CLK),
    .reset(RESET),
    .ce   (CE),
    .qa   (QA_Y),
    .qb   (QB_Y),
    .cl_n (CL2n),
    .count(count_y),
    .err  (err_y)
  );

  assign ld1_fall = ld1_q & ~LD1n;
  assign ld2_fall = ld2_q & ~LD2n;
  assign ck1_rise = ~ck1_q & CK1;
  assign mode     = {SHFT1, SHFT0};

  // Edge history resets to idle levels so release never fakes an edge
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ld1_q   <= 1'b1;
      ld2_q   <= 1'b1;
      ck1_q   <= 1'b1;
      hold_x  <= '0;
      hold_y  <= '0;
      shifter <= '0;
    end else if (CE) begin
      ld1_q <= LD1n;
      ld2_q <= LD2n;
      ck1_q <= CK1;
      if (ld1_fall) hold_x <= count_x;
      if (ld2_fall) hold_y <= count_y;
      if (ck1_rise) begin
        unique case (mode)
          MODE_HOLD: shifter <= shifter;
          MODE_SR:   shifter <= {1'b0, shifter[2*CNT_W-1:1]};
          MODE_SL:   shifter <= {shifter[2*CNT_W-2:0], 1'b0};
          MODE_LOAD: shifter <= {hold_y, hold_x};
        endcase
      end
    end
  end

  assign DOUT  = shifter[7:0];
  assign SDATA = shifter[0];
  assign ERR   = err_x | err_y;

endmodule

// File: tb/tb_trackball_position_counter.sv
// Self-checking bench for trackball_position_counter:
// directed corners, shifter vector table and random moves.
module tb_trackball_position_counter;

  localparam int SYNC_STAGES = 2;
  localparam int FILT_N      = 3;
  localparam int LAT         = SYNC_STAGES + FILT_N;
  localparam int SETTLE      = FILT_N + 4;

  logic       CLK   = 1'b0;
  logic       RESET = 1'b1;
  logic       CE    = 1'b1;
  logic       QA_X  = 1'b0;
  logic       QB_X  = 1'b0;
  logic       QA_Y  = 1'b0;
  logic       QB_Y  = 1'b0;
  logic       LD1n  = 1'b1;
  logic       LD2n  = 1'b1;
  logic       CL1n  = 1'b1;
  logic       CL2n  = 1'b1;
  logic       SHFT0 = 1'b0;
  logic       SHFT1 = 1'b0;
  logic       CK1   = 1'b0;
  logic [7:0] DOUT;
  logic       SDATA;
  logic       ERR;

  int checks = 0;
  int errors = 0;
  bit ce_rand  = 1'b0;
  bit ce_level = 1'b1;

  // Model: phase index into the Gray sequence and count per axis
  int pos[2];
  int cnt[2];
  logic [1:0] gray [4];

  typedef struct {
    logic [1:0] mode;
    logic [7:0] dout;
    logic       sdata;
  } vec_t;
  vec_t tbl[12];

  trackball_position_counter #(
    .CNT_W      (8),
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_N     (FILT_N)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .CE   (CE),
    .QA_X (QA_X),
    .QB_X (QB_X),
    .QA_Y (QA_Y),
    .QB_Y (QB_Y),
    .LD1n (LD1n),
    .LD2n (LD2n),
    .CL1n (CL1n),
    .CL2n (CL2n),
    .SHFT0(SHFT0),
    .SHFT1(SHFT1),
    .CK1  (CK1),
    .DOUT (DOUT),
    .SDATA(SDATA),
    .ERR  (ERR)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK)
    CE = ce_rand ? ($urandom_range(0, 3) != 0) : ce_level;

  initial begin
    #900_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic wait_ce(int n);
    int k = 0;
    while (k < n) begin
      @(posedge CLK);
      if (CE) k++;
    end
    @(negedge CLK);
  endtask

  task automatic drive(int ax);
    logic [1:0] g;
    g = gray[pos[ax]];
    if (ax == 0) begin
      QA_X = g[1];
      QB_X = g[0];
    end else begin
      QA_Y = g[1];
      QB_Y = g[0];
    end
  endtask

  task automatic move(int ax, int dir);
    pos[ax] = (pos[ax] + dir + 4) % 4;
    cnt[ax] = (cnt[ax] + dir + 256) % 256;
    drive(ax);
    wait_ce(SETTLE);
  endtask

  task automatic pulse_ck();
    CK1 = 1'b1;
    wait_ce(1);
    CK1 = 1'b0;
    wait_ce(1);
  endtask

  task automatic read_counts(string tag);
    LD1n = 1'b0;
    LD2n = 1'b0;
    wait_ce(2);
    LD1n = 1'b1;
    LD2n = 1'b1;
    wait_ce(1);
    {SHFT1, SHFT0} = 2'b11;
    pulse_ck();
    chk({tag, "_x"}, 16'(DOUT), 16'(cnt[0]));
    {SHFT1, SHFT0} = 2'b01;
    repeat (8) pulse_ck();
    chk({tag, "_y"}, 16'(DOUT), 16'(cnt[1]));
    {SHFT1, SHFT0} = 2'b00;
  endtask

  initial begin
    gray[0] = 2'b00;
    gray[1] = 2'b01;
    gray[2] = 2'b11;
    gray[3] = 2'b10;
    pos = '{0, 0};
    cnt = '{0, 0};
    tbl[0]  = '{2'b11, 8'h34, 1'b0};
    tbl[1]  = '{2'b10, 8'h68, 1'b0};
    tbl[2]  = '{2'b10, 8'hD0, 1'b0};
    tbl[3]  = '{2'b10, 8'hA0, 1'b0};
    tbl[4]  = '{2'b10, 8'h40, 1'b0};
    tbl[5]  = '{2'b00, 8'h40, 1'b0};
    tbl[6]  = '{2'b01, 8'hA0, 1'b0};
    tbl[7]  = '{2'b01, 8'hD0, 1'b0};
    tbl[8]  = '{2'b01, 8'h68, 1'b0};
    tbl[9]  = '{2'b01, 8'h34, 1'b0};
    tbl[10] = '{2'b01, 8'h1A, 1'b0};
    tbl[11] = '{2'b01, 8'h8D, 1'b1};

    // Reset with inputs toggling
    RESET = 1'b1;
    repeat (4) begin
      @(negedge CLK);
      QA_X = ~QA_X;
      QB_Y = ~QB_Y;
    end
    RESET = 1'b0;
    chk("rst_dout", 16'(DOUT), 16'h00);
    chk("rst_sdata", 16'(SDATA), 16'h0);
    chk("rst_err", 16'(ERR), 16'h0);
    wait_ce(SETTLE);
    read_counts("rst");

    // X forward 20 edges, then Y reverse 3
    repeat (20) move(0, 1);
    read_counts("xfwd");
    repeat (3) move(1, -1);
    read_counts("yrev");

    // Wrap in both directions
    while (cnt[0] != 255) move(0, -1);
    read_counts("at_ff");
    move(0, 1);
    read_counts("wrap_up");
    move(0, -1);
    read_counts("wrap_dn");

    // Clear and load in the exact cycle of a forward step
    while (cnt[0] != 7) move(0, 1);
    pos[0] = (pos[0] + 1) % 4;
    drive(0);
    repeat (LAT) @(negedge CLK);
    CL1n = 1'b0;
    LD1n = 1'b0;
    @(negedge CLK);
    CL1n = 1'b1;
    LD1n = 1'b1;
    cnt[0] = 1;
    wait_ce(SETTLE);
    {SHFT1, SHFT0} = 2'b11;
    pulse_ck();
    chk("cl_ld_hold", 16'(DOUT), 16'h07);
    read_counts("cl_cnt");

    // Short glitch is filtered out
    QA_X = ~QA_X;
    @(negedge CLK);
    @(negedge CLK);
    QA_X = ~QA_X;
    wait_ce(SETTLE);
    read_counts("glitch");
    chk("err_clear", 16'(ERR), 16'h0);

    // Two-bit jump: no count, sticky error
    pos[0] = (pos[0] + 2) % 4;
    drive(0);
    wait_ce(SETTLE);
    chk("err_set", 16'(ERR), 16'h1);
    read_counts("jump");

    // Shifter vector table from hold = {0x12, 0x34}
    while (cnt[0] != 8'h34) move(0, 1);
    while (cnt[1] != 8'h12) move(1, 1);
    LD1n = 1'b0;
    LD2n = 1'b0;
    wait_ce(2);
    LD1n = 1'b1;
    LD2n = 1'b1;
    wait_ce(1);
    for (int i = 0; i < 12; i++) begin
      {SHFT1, SHFT0} = tbl[i].mode;
      pulse_ck();
      chk($sformatf("tbl%0d_dout", i), 16'(DOUT), 16'(tbl[i].dout));
      chk($sformatf("tbl%0d_sdata", i), 16'(SDATA), 16'(tbl[i].sdata));
    end

    // LD edge and CK1 load together: shifter sees the old hold
    move(0, 1);
    {SHFT1, SHFT0} = 2'b11;
    LD1n = 1'b0;
    CK1  = 1'b1;
    wait_ce(1);
    LD1n = 1'b1;
    CK1  = 1'b0;
    wait_ce(1);
    chk("ld_ck_old", 16'(DOUT), 16'h34);
    pulse_ck();
    chk("ld_ck_new", 16'(DOUT), 16'h35);
    {SHFT1, SHFT0} = 2'b00;

    // Random moves with an irregular clock enable
    ce_rand = 1'b1;
    for (int i = 0; i < 160; i++) begin
      move(int'($urandom_range(0, 1)), ($urandom_range(0, 1) != 0) ? 1 : -1);
      if (i % 20 == 19) read_counts($sformatf("rnd%0d", i));
    end
    chk("err_sticky", 16'(ERR), 16'h1);

    // Reset mid-operation with CE low
    ce_rand  = 1'b0;
    ce_level = 1'b0;
    pos = '{0, 0};
    drive(0);
    drive(1);
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    ce_level = 1'b1;
    cnt = '{0, 0};
    chk("mid_rst_dout", 16'(DOUT), 16'h00);
    chk("mid_rst_err", 16'(ERR), 16'h0);
    wait_ce(SETTLE);
    read_counts("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trackball_position_counter.md
Name: trackball_position_counter

Overview:
- Counting end of the trackball position-control interface: decodes X/Y quadrature, accumulates per-axis deltas, and consumes the LD/CL/SHFT/CK1 strobes from the position-control timing logic.
- LD strobes latch counts into holding registers. CL strobes clear the live counters. CK1 edges step a 16-bit shifter that presents position data to the CPU input mux.
- Sits between the trackball input pins and the CPU data bus read path.

Parameters:
CNT_W, 8, width of each axis counter and holding register
SYNC_STAGES, 2, synchroniser depth on quadrature inputs (min 2)
FILT_N, 3, consecutive equal samples required to accept a quadrature level

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous, active-high reset
CE  in  1  clock enable (5 MHz pixel rate); all state except synchronisers advances only when CE=1
QA_X  in  1  X-axis quadrature phase A (asynchronous)
QB_X  in  1  X-axis quadrature phase B (asynchronous)
QA_Y  in  1  Y-axis quadrature phase A (asynchronous)
QB_Y  in  1  Y-axis quadrature phase B (asynchronous)
LD1n  in  1  active-low, load X counter into hold_X
LD2n  in  1  active-low, load Y counter into hold_Y
CL1n  in  1  active-low, clear X counter
CL2n  in  1  active-low, clear Y counter
SHFT0  in  1  shifter mode bit 0
SHFT1  in  1  shifter mode bit 1
CK1  in  1  shifter step clock (sampled, not used as a clock)
DOUT  out  8  shifter bits [7:0], to CPU input mux
SDATA  out  1  serial output, shifter bit 0
ERR  out  1  sticky illegal-transition flag (either axis)

Behaviour:
- Reset: counters, hold_X/Y, shifter, filter state all 0; DOUT=0, SDATA=0, ERR=0. Decoder previous-state register loads the current filtered input on the first CE after reset, so no spurious count.
- Input path: SYNC_STAGES flops on CLK (not CE-gated), then the filter. The filtered level updates only after FILT_N consecutive CE samples agree.
- Decoder: Gray sequence 00->01->11->10->00 counts +1; the reverse counts -1. No change counts 0. A double-bit change counts 0 and sets ERR; ERR clears only on RESET.
- Counter arithmetic: modulo 2^CNT_W (wraps; 0xFF+1=0x00, 0x00-1=0xFF).
- CL1n/CL2n are level-sensitive. While low, the counter holds 0. A step in the same CE cycle as the clear yields ±1, so no count is lost.
- LD1n/LD2n are falling-edge detected on CE samples. The hold register captures the pre-update counter value of that cycle, so the same-cycle step and clear are not included.
- LD and CL asserted in the same cycle: hold gets the old value, the counter is cleared (then ±1 per the step rule).
- CK1: rising edge detected on CE samples. The shifter acts only on that cycle, with mode {SHFT1,SHFT0}:
  - 00: hold
  - 01: shift right, MSB fill 0
  - 10: shift left, LSB fill 0
  - 11: parallel load {hold_Y, hold_X}
- Shifter latency: a parallel load on a CK1 edge is visible on DOUT/SDATA the next CLK.
- An LD edge and a CK1 load in the same cycle: the shifter takes the old hold value (registered semantics).
- RESET mid-operation: everything returns to reset values on the next CLK regardless of CE.

Decomposition:
- Shared package: quadrature state typedef (2-bit Gray), shifter mode localparams (MODE_HOLD, MODE_SR, MODE_SL, MODE_LOAD).
- Sub-module: quad_axis_decoder (sync + filter + Gray decode + counter + clear), instantiated twice (X, Y). Top level holds the LD/CK1 edge detectors, hold registers and the shifter.

Test Plan:
- RESET high 2 CLK with inputs toggling -> DOUT=0x00, ERR=0, counters 0 after release; first CE produces no count.
- X forward 5 full cycles (20 edges, each held ≥FILT_N CE), pulse LD1n, CK1 with mode 11 -> DOUT=0x14; Y reverse 3 edges, LD2n, load, then 8 CK1 shift-right -> DOUT=0xFD.
- X counter at 0xFF plus one forward edge -> hold_X reads 0x00 after LD1n; from 0x00 one reverse edge -> 0xFF.
- CL1n low in the same CE cycle as a forward X edge, counter previously 0x07 -> counter 0x01. LD1n in that same cycle -> hold_X=0x07.
- Glitch on QA_X shorter than FILT_N CE samples -> no count. A forced 00->11 jump -> count unchanged, ERR=1 until RESET.
- hold={0x12,0x34}, mode 11 then mode 10 with 4 CK1 edges -> DOUT=0x40; SDATA tracks bit 0 each step; mode 00 with CK1 -> unchanged.
